uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver paired with the existing uart transmitter; consumes the TX line it drives (8N1, LSB first, idle high).
- Recovers bytes by mid-bit sampling.
- Presents each byte zero-extended on a 32-bit data word, with a valid pulse and a sticky interrupt for the core to service.
- Sits between the pad/loopback RX line and the core's memory-mapped UART register block.

Parameters:
- CLKS_PER_BIT, 206, clock cycles per bit period. Must match the transmitter's divisor; must be >= 4; even values only.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the start-edge detection to the start-bit mid-sample (derived; do not override).

Ports:
- clock  input  1  system clock, rising edge
- nRst  input  1  synchronous active-low reset
- RX  input  1  asynchronous serial input, idle high
- rd_ack  input  1  one-cycle pulse from the core: byte consumed, clear interrupt/flags
- data  output  32  last received byte in [7:0]; [31:8] always 0
- data_valid  output  1  one-cycle pulse when data updates
- interrupt  output  1  sticky; set on byte received, cleared by rd_ack
- frame_err  output  1  sticky; stop bit sampled 0, cleared by rd_ack
- overrun  output  1  sticky; byte received while interrupt still set, cleared by rd_ack
- parity_err  output  1  sticky parity failure (see Optional Feature), cleared by rd_ack

Behaviour:
- Reset: clock and reset are one clock; reset is synchronous, active-low. With nRst=0 at a rising edge, all outputs go to 0, the FSM goes to IDLE, counters go to 0, and both synchronizer flops go to 1. A reset mid-frame abandons the frame with no partial update.
- Synchronizer: RX passes through 2 flops, giving rx_s. Start is detected when rx_s is 0 and its previous value was 1.
- IDLE: on start detect, load the counter with HALF_BIT-1 and go to START.
- START: count down. At 0, sample rx_s:
  - rx_s=1 is a glitch: return to IDLE with no flags set.
  - rx_s=0: reload CLKS_PER_BIT-1, set bit index 0, go to DATA.
- DATA: at each counter expiry, shift rx_s into shift[bit_idx] (LSB first) and reload. After bit 7, go to PARITY (macro) or STOP.
- STOP: at counter expiry, sample rx_s:
  - rx_s=1: on the next edge, data[7:0] <= shift and data_valid=1 for exactly one cycle. If interrupt is already 1 and rd_ack is not asserted that cycle, set overrun (data is overwritten). Set interrupt.
  - rx_s=0: set frame_err. data, data_valid and interrupt are unchanged.
  - Either way, return to IDLE. A new start requires rx_s to be seen high, then low.
- Latency: data_valid rises HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the start-detect cycle, plus 2 cycles of synchronizer delay from the raw RX edge.
- rd_ack clears interrupt, frame_err, overrun and parity_err on the next edge.
- rd_ack in the same cycle as a new byte completion: the set wins. interrupt stays 1 and overrun is not set.
- rd_ack while IDLE with nothing pending has no effect.
- The FSM is never blocked by an unserviced interrupt; reception continues.
- Back-to-back frames: a start edge immediately after the stop mid-sample is accepted.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state follows DATA and samples one bit after bit 7. If XOR of the 8 data bits and the parity bit is 1, parity_err is set. The byte is still delivered (data_valid, interrupt) when the stop bit is good. Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, 8N1 framing, and parity_err is tied to 0.

Test Plan (CLKS_PER_BIT=16, macro undefined unless stated):
- Reset: hold nRst=0 for 3 cycles with RX=1, then release -> all outputs 0. A drop of nRst mid-frame -> no data_valid for that frame.
- Receive 0xA5 8N1 -> data=32'h000000A5. data_valid pulses once, exactly 8+144+1 cycles after start detect. interrupt=1, frame_err=0.
- RX low for 4 cycles only (glitch) -> FSM returns to IDLE. No data_valid and no flags. A following valid 0x3C frame is received correctly.
- Stop bit driven 0 on a 0x55 frame -> frame_err=1, data unchanged, interrupt unchanged. rd_ack -> frame_err=0.
- Two frames 0x01 then 0x02 with no rd_ack -> data=0x02, overrun=1, interrupt=1. Repeat with rd_ack pulsed on the data_valid cycle of 0x02 -> overrun=0, interrupt=1.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> data=0x07, parity_err=0. 0x07 with parity bit 0 -> parity_err=1 and data_valid still pulses.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (8E1 when UART_RX_PARITY_EN is defined).
//
// Recovers bytes from an idle-high, LSB-first serial line by sampling each
// bit at its midpoint. Every received byte is presented zero-extended on a
// 32-bit word together with a one-cycle valid pulse and a sticky interrupt.
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit after
// bit 7 and drives parity_err; when undefined parity_err is tied to 0).
//
// Ports:
//   clock       in   system clock, rising edge
//   nRst        in   synchronous active-low reset
//   RX          in   asynchronous serial input, idle high
//   rd_ack      in   one-cycle pulse: byte consumed, clears sticky flags
//   data        out  [7:0] last received byte, [31:8] always 0
//   data_valid  out  one-cycle pulse when data updates
//   interrupt   out  sticky, set on byte received
//   frame_err   out  sticky, stop bit sampled low
//   overrun     out  sticky, byte received while interrupt still pending
//   parity_err  out  sticky, parity failure (macro builds only)
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a high-to-low transition on the synchronised line
// S_START   | counting to the start-bit midpoint, rejects glitches
// S_DATA    | sampling data bits 0..7 at their midpoints
// S_PARITY  | sampling the parity bit (macro builds only)
// S_STOP    | sampling the stop bit, delivering the byte or flagging framing

module uart_rx #(
    parameter int CLKS_PER_BIT = 206
) (
    input  logic        clock,
    input  logic        nRst,
    input  logic        RX,
    input  logic        rd_ack,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        interrupt,
    output logic        frame_err,
    output logic        overrun,
    output logic        parity_err
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          data_valid_q, data_valid_d;
    logic          interrupt_q, interrupt_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic          parity_err_q, parity_err_d;
`endif

    logic start_det;
    logic cnt_zero;

    assign start_det = rx_prev_q && !rx_s_q;
    assign cnt_zero  = (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        interrupt_d  = interrupt_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        // Clears are applied first so that a set in the same cycle wins.
        if (rd_ack) begin
            interrupt_d = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    cnt_d   = HALF_LOAD;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end

            S_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d[bit_idx_q] = rx_s_q;
                    cnt_d              = BIT_LOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Even parity: data bits plus parity bit must XOR to 0.
                    if (^{shift_q, rx_s_q}) begin
                        parity_err_d = 1'b1;
                    end
                    cnt_d   = BIT_LOAD;
                    state_d = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (rx_s_q) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        if (interrupt_q && !rd_ack) begin
                            overrun_d = 1'b1;
                        end
                        interrupt_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nRst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            interrupt_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= RX;
            rx_s_q       <= rx_meta_q;
            rx_prev_q    <= rx_s_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            interrupt_q  <= interrupt_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = {24'h000000, data_q};
    assign data_valid = data_valid_q;
    assign interrupt  = interrupt_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int C = 16;
    localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Cycles from driving the start-bit fall on RX to seeing data_valid:
    // 2 synchroniser cycles + HALF_BIT + (9 + parity) bit periods + 1.
    localparam int LAT = 2 + H + (9 + PBITS) * C + 1;

    logic        clock;
    logic        nRst;
    logic        RX;
    logic        rd_ack;
    logic [31:0] data;
    logic        data_valid;
    logic        interrupt;
    logic        frame_err;
    logic        overrun;
    logic        parity_err;

    int pass_cnt;
    int total_cnt;
    int cyc;
    int dv_count;
    int dv_cyc;
    logic [31:0] dv_data;
    int last_fall;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clock     (clock),
        .nRst      (nRst),
        .RX        (RX),
        .rd_ack    (rd_ack),
        .data      (data),
        .data_valid(data_valid),
        .interrupt (interrupt),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        dv_count = 0;
        dv_cyc   = 0;
        dv_data  = 32'h0;
    end
    always @(negedge clock) begin
        if (data_valid === 1'b1) begin
            dv_count = dv_count + 1;
            dv_cyc   = cyc;
            dv_data  = data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clock);
        RX = 1'b0;
        last_fall = cyc;
        repeat (C) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (C) @(negedge clock);
        end
`ifdef UART_RX_PARITY_EN
        RX = ^b;
        repeat (C) @(negedge clock);
`endif
        RX = stop;
        repeat (C) @(negedge clock);
        RX = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_p(input logic [7:0] b, input logic par);
        @(negedge clock);
        RX = 1'b0;
        last_fall = cyc;
        repeat (C) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (C) @(negedge clock);
        end
        RX = par;
        repeat (C) @(negedge clock);
        RX = 1'b1;
        repeat (C) @(negedge clock);
    endtask
`endif

    task automatic pulse_ack();
        @(negedge clock);
        rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
    endtask

    // Raises rd_ack for one cycle, off cycles after a frame started together.
    task automatic ack_at_offset(input int off);
        int t0;
        @(negedge clock);
        t0 = cyc;
        while (cyc < t0 + off) @(negedge clock);
        rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        int dv0;
        nRst = 1'b0;
        RX = 1'b1;
        rd_ack = 1'b0;
        repeat (3) @(negedge clock);
        nRst = 1'b1;
        @(negedge clock);
        total_cnt++; if (data !== 32'h0) $display("FAIL reset_data got %h want %h", data, 32'h0); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_dv got %b want 0", data_valid); else pass_cnt++;
        total_cnt++; if (interrupt !== 1'b0) $display("FAIL reset_int got %b want 0", interrupt); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_fe got %b want 0", frame_err); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ovr got %b want 0", overrun); else pass_cnt++;
        total_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_pe got %b want 0", parity_err); else pass_cnt++;

        // Reset dropped in the middle of an 0xFF frame, line high around it.
        dv0 = dv_count;
        @(negedge clock);
        RX = 1'b0;
        repeat (C) @(negedge clock);
        RX = 1'b1;
        repeat (3 * C) @(negedge clock);
        nRst = 1'b0;
        repeat (3) @(negedge clock);
        nRst = 1'b1;
        repeat (10 * C) @(negedge clock);
        total_cnt++; if (dv_count - dv0 !== 0) $display("FAIL midreset_dv got %0d want 0", dv_count - dv0); else pass_cnt++;
        total_cnt++; if (data !== 32'h0) $display("FAIL midreset_data got %h want %h", data, 32'h0); else pass_cnt++;
        total_cnt++; if (interrupt !== 1'b0) $display("FAIL midreset_int got %b want 0", interrupt); else pass_cnt++;
    endtask

    task automatic test_basic();
        int dv0;
        dv0 = dv_count;
        send_frame(8'hA5, 1'b1);
        total_cnt++; if (dv_count - dv0 !== 1) $display("FAIL basic_dv_count got %0d want 1", dv_count - dv0); else pass_cnt++;
        total_cnt++; if (data !== 32'h000000A5) $display("FAIL basic_data got %h want %h", data, 32'h000000A5); else pass_cnt++;
        total_cnt++; if (dv_data !== 32'h000000A5) $display("FAIL basic_dv_data got %h want %h", dv_data, 32'h000000A5); else pass_cnt++;
        total_cnt++; if (dv_cyc - last_fall !== LAT) $display("FAIL basic_latency got %0d want %0d", dv_cyc - last_fall, LAT); else pass_cnt++;
        total_cnt++; if (interrupt !== 1'b1) $display("FAIL basic_int got %b want 1", interrupt); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL basic_fe got %b want 0", frame_err); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (interrupt !== 1'b0) $display("FAIL basic_ack_int got %b want 0", interrupt); else pass_cnt++;
        // Ack with nothing pending changes nothing.
        pulse_ack();
        total_cnt++; if (data !== 32'h000000A5) $display("FAIL idle_ack_data got %h want %h", data, 32'h000000A5); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int dv0;
        dv0 = dv_count;
        @(negedge clock);
        RX = 1'b0;
        repeat (4) @(negedge clock);
        RX = 1'b1;
        repeat (3 * C) @(negedge clock);
        total_cnt++; if (dv_count - dv0 !== 0) $display("FAIL glitch_dv got %0d want 0", dv_count - dv0); else pass_cnt++;
        total_cnt++; if ({interrupt, frame_err, overrun} !== 3'b000) $display("FAIL glitch_flags got %b want 000", {interrupt, frame_err, overrun}); else pass_cnt++;
        send_frame(8'h3C, 1'b1);
        total_cnt++; if (data !== 32'h0000003C) $display("FAIL glitch_next_data got %h want %h", data, 32'h0000003C); else pass_cnt++;
        total_cnt++; if (interrupt !== 1'b1) $display("FAIL glitch_next_int got %b want 1", interrupt); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int dv0;
        dv0 = dv_count;
        send_frame(8'h55, 1'b0);
        repeat (2) @(negedge clock);
        total_cnt++; if (frame_err !== 1'b1) $display("FAIL ferr_set got %b want 1", frame_err); else pass_cnt++;
        total_cnt++; if (data !== 32'h0000003C) $display("FAIL ferr_data got %h want %h", data, 32'h0000003C); else pass_cnt++;
        total_cnt++; if (interrupt !== 1'b1) $display("FAIL ferr_int got %b want 1", interrupt); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ferr_ovr got %b want 0", overrun); else pass_cnt++;
        total_cnt++; if (dv_count - dv0 !== 0) $display("FAIL ferr_dv got %0d want 0", dv_count - dv0); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL ferr_clear got %b want 0", frame_err); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int dv0;
        pulse_ack();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        total_cnt++; if (data !== 32'h00000002) $display("FAIL ovr_data got %h want %h", data, 32'h00000002); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else pass_cnt++;
        total_cnt++; if (interrupt !== 1'b1) $display("FAIL ovr_int got %b want 1", interrupt); else pass_cnt++;
        pulse_ack();
        total_cnt++; if ({interrupt, overrun} !== 2'b00) $display("FAIL ovr_clear got %b want 00", {interrupt, overrun}); else pass_cnt++;

        // Ack lands in the completion cycle of the second byte: set wins.
        send_frame(8'h01, 1'b1);
        dv0 = dv_count;
        fork
            send_frame(8'h02, 1'b1);
            ack_at_offset(LAT - 1);
        join
        total_cnt++; if (dv_count - dv0 !== 1) $display("FAIL ackwin_dv got %0d want 1", dv_count - dv0); else pass_cnt++;
        total_cnt++; if (data !== 32'h00000002) $display("FAIL ackwin_data got %h want %h", data, 32'h00000002); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ackwin_ovr got %b want 0", overrun); else pass_cnt++;
        total_cnt++; if (interrupt !== 1'b1) $display("FAIL ackwin_int got %b want 1", interrupt); else pass_cnt++;
        pulse_ack();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int dv0;
        pulse_ack();
        send_frame_p(8'h07, 1'b1);
        total_cnt++; if (data !== 32'h00000007) $display("FAIL par_ok_data got %h want %h", data, 32'h00000007); else pass_cnt++;
        total_cnt++; if (parity_err !== 1'b0) $display("FAIL par_ok_pe got %b want 0", parity_err); else pass_cnt++;
        pulse_ack();
        dv0 = dv_count;
        send_frame_p(8'h07, 1'b0);
        total_cnt++; if (parity_err !== 1'b1) $display("FAIL par_bad_pe got %b want 1", parity_err); else pass_cnt++;
        total_cnt++; if (dv_count - dv0 !== 1) $display("FAIL par_bad_dv got %0d want 1", dv_count - dv0); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (parity_err !== 1'b0) $display("FAIL par_clear got %b want 0", parity_err); else pass_cnt++;
    endtask
`endif

    // Random bytes with random gaps and random servicing, checked against a
    // model of the sticky-flag rules.
    task automatic test_random();
        logic [7:0]  b;
        logic [31:0] exp_data;
        logic        exp_int;
        logic        exp_ovr;
        int          dv0;
        int          gap;
        int          do_ack;
        pulse_ack();
        exp_int = 1'b0;
        exp_ovr = 1'b0;
        for (int n = 0; n < 10; n++) begin
            b      = 8'($urandom);
            gap    = int'($urandom_range(0, 3));
            do_ack = int'($urandom_range(0, 1));
            dv0    = dv_count;
            send_frame(b, 1'b1);
            exp_ovr  = exp_ovr | exp_int;
            exp_int  = 1'b1;
            exp_data = {24'h000000, b};
            total_cnt++; if (dv_count - dv0 !== 1) $display("FAIL rnd%0d_dv got %0d want 1", n, dv_count - dv0); else pass_cnt++;
            total_cnt++; if (dv_data !== exp_data) $display("FAIL rnd%0d_data got %h want %h", n, dv_data, exp_data); else pass_cnt++;
            total_cnt++; if (dv_cyc - last_fall !== LAT) $display("FAIL rnd%0d_latency got %0d want %0d", n, dv_cyc - last_fall, LAT); else pass_cnt++;
            total_cnt++; if (interrupt !== exp_int) $display("FAIL rnd%0d_int got %b want %b", n, interrupt, exp_int); else pass_cnt++;
            total_cnt++; if (overrun !== exp_ovr) $display("FAIL rnd%0d_ovr got %b want %b", n, overrun, exp_ovr); else pass_cnt++;
            total_cnt++; if (frame_err !== 1'b0) $display("FAIL rnd%0d_fe got %b want 0", n, frame_err); else pass_cnt++;
            if (do_ack != 0) begin
                pulse_ack();
                exp_int = 1'b0;
                exp_ovr = 1'b0;
            end
            repeat (gap) @(negedge clock);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        last_fall = 0;
        nRst      = 1'b0;
        RX        = 1'b1;
        rd_ack    = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
